// File: rtl/vend_fsm.sv
// Vending machine controller: coin acceptance with credit limit, item
// selection with affordability enables, timed dispense strobe and 5-unit
// change return. Every output comes straight from a register.
module vend_fsm #(
   parameter int PRICE_CHILD = 10,
   parameter int PRICE_MEN   = 15,
   parameter int PRICE_WOMEN = 20,
   parameter int CREDIT_MAX  = 60,
   parameter int BLINK_DIV   = 4,
   parameter int DISP_CYCLES = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       coin5,
   input  logic       coin10,
   input  logic       sw_child,
   input  logic       sw_men,
   input  logic       sw_women,
   input  logic       cancel,
   output logic [1:0] state,
   output logic       blink,
   output logic       en_child,
   output logic       en_men,
   output logic       en_women,
   output logic       vend_child,
   output logic       vend_men,
   output logic       vend_women,
   output logic       change_out,
   output logic       coin_reject,
   output logic [5:0] credit
);

   localparam logic [1:0] S_IDLE     = 2'b00;
   localparam logic [1:0] S_SELECT   = 2'b01;
   localparam logic [1:0] S_DISPENSE = 2'b10;
   localparam logic [1:0] S_CHANGE   = 2'b11;

   localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam int DW = (DISP_CYCLES > 1) ? $clog2(DISP_CYCLES) : 1;
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
   localparam logic [DW-1:0] DISP_LAST  = DW'(DISP_CYCLES - 1);

   // Prices and limit widened by one bit so credit + coin never wraps.
   localparam logic [6:0] P_CHILD = 7'(PRICE_CHILD);
   localparam logic [6:0] P_MEN   = 7'(PRICE_MEN);
   localparam logic [6:0] P_WOMEN = 7'(PRICE_WOMEN);
   localparam logic [6:0] C_MAX   = 7'(CREDIT_MAX);

   logic [1:0]    state_reg, state_next;
   logic [5:0]    credit_reg, credit_next;
   logic [2:0]    en_reg, en_next;       // {child, men, women}
   logic [2:0]    vend_reg, vend_next;   // {child, men, women}, doubles as the item latch
   logic          change_reg, change_next;
   logic          reject_reg, reject_next;
   logic          blink_reg, blink_next;
   logic [BW-1:0] blink_cnt_reg, blink_cnt_next;
   logic [DW-1:0] disp_cnt_reg, disp_cnt_next;

   logic          coin_any;
   logic          coin_ok;
   logic          cancel_sel;
   logic [6:0]    coin_val;
   logic [6:0]    sum;
   logic [6:0]    price;
   logic [2:0]    sel_valid;

   // Decide whether this cycle's coin is taken; cancel in SELECT steals it.
   always_comb begin
      coin_any   = coin5 | coin10;
      coin_val   = coin10 ? 7'd10 : 7'd5;
      cancel_sel = (state_reg == S_SELECT) && cancel;
      coin_ok    = coin_any && !(coin5 && coin10)
                   && ((state_reg == S_IDLE) || (state_reg == S_SELECT))
                   && !cancel_sel
                   && (({1'b0, credit_reg} + coin_val) <= C_MAX);
      // Enables are registered copies of affordability, so they gate the switches directly.
      sel_valid  = {sw_child, sw_men, sw_women} & en_reg;
   end

   // Main state machine and credit bookkeeping.
   always_comb begin
      state_next    = state_reg;
      credit_next   = credit_reg;
      vend_next     = vend_reg;
      disp_cnt_next = disp_cnt_reg;
      change_next   = 1'b0;
      reject_next   = coin_any && !coin_ok;
      sum           = {1'b0, credit_reg} + (coin_ok ? coin_val : 7'd0);
      price         = 7'd0;
      en_next       = 3'b000;

      case (state_reg)
         S_IDLE: begin
            if (coin_ok) begin
               credit_next = 6'(sum);
               state_next  = S_SELECT;
            end
         end
         S_SELECT: begin
            if (cancel) begin
               state_next = S_CHANGE;
            end else begin
               // Fixed priority child > men > women among affordable selections.
               if (sel_valid[2]) begin
                  price     = P_CHILD;
                  vend_next = 3'b100;
               end else if (sel_valid[1]) begin
                  price     = P_MEN;
                  vend_next = 3'b010;
               end else if (sel_valid[0]) begin
                  price     = P_WOMEN;
                  vend_next = 3'b001;
               end
               credit_next = 6'(sum - price);
               if (sel_valid != 3'b000) begin
                  state_next    = S_DISPENSE;
                  disp_cnt_next = '0;
               end
            end
         end
         S_DISPENSE: begin
            if (disp_cnt_reg == DISP_LAST) begin
               vend_next  = 3'b000;
               state_next = (credit_reg != 6'd0) ? S_CHANGE : S_IDLE;
            end else begin
               disp_cnt_next = disp_cnt_reg + DW'(1);
            end
         end
         S_CHANGE: begin
            if (credit_reg != 6'd0) begin
               credit_next = credit_reg - 6'd5;
               change_next = 1'b1;
            end else begin
               state_next = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase

      // Enables track the credit that will be visible alongside them.
      if (state_next == S_SELECT) begin
         en_next = {({1'b0, credit_next} >= P_CHILD),
                    ({1'b0, credit_next} >= P_MEN),
                    ({1'b0, credit_next} >= P_WOMEN)};
      end
   end

   // Free-running blink divider, independent of the FSM.
   always_comb begin
      blink_next     = blink_reg;
      blink_cnt_next = blink_cnt_reg + BW'(1);
      if (blink_cnt_reg == BLINK_LAST) begin
         blink_cnt_next = '0;
         blink_next     = ~blink_reg;
      end
   end

   // State and output registers; reset clears everything including counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= S_IDLE;
         credit_reg    <= '0;
         en_reg        <= '0;
         vend_reg      <= '0;
         change_reg    <= 1'b0;
         reject_reg    <= 1'b0;
         blink_reg     <= 1'b0;
         blink_cnt_reg <= '0;
         disp_cnt_reg  <= '0;
      end else begin
         state_reg     <= state_next;
         credit_reg    <= credit_next;
         en_reg        <= en_next;
         vend_reg      <= vend_next;
         change_reg    <= change_next;
         reject_reg    <= reject_next;
         blink_reg     <= blink_next;
         blink_cnt_reg <= blink_cnt_next;
         disp_cnt_reg  <= disp_cnt_next;
      end
   end

   assign state       = state_reg;
   assign credit      = credit_reg;
   assign en_child    = en_reg[2];
   assign en_men      = en_reg[1];
   assign en_women    = en_reg[0];
   assign vend_child  = vend_reg[2];
   assign vend_men    = vend_reg[1];
   assign vend_women  = vend_reg[0];
   assign change_out  = change_reg;
   assign coin_reject = reject_reg;
   assign blink       = blink_reg;

endmodule

// File: tb/tb_vend_fsm.sv
// Bench for vend_fsm: table of single-cycle vectors, hand-written multi-cycle
// scenarios, then random traffic, all checked against a behavioural model.
module tb_vend_fsm;

   localparam int PC = 10, PM = 15, PW = 20, CMAX = 60, BDIV = 4, DISP = 8;

   logic clk = 1'b0;
   logic rst, coin5, coin10, sw_child, sw_men, sw_women, cancel;
   logic [1:0] state;
   logic blink, en_child, en_men, en_women, vend_child, vend_men, vend_women;
   logic change_out, coin_reject;
   logic [5:0] credit;

   vend_fsm #(.PRICE_CHILD(PC), .PRICE_MEN(PM), .PRICE_WOMEN(PW),
              .CREDIT_MAX(CMAX), .BLINK_DIV(BDIV), .DISP_CYCLES(DISP)) dut (
      .clk(clk), .rst(rst), .coin5(coin5), .coin10(coin10),
      .sw_child(sw_child), .sw_men(sw_men), .sw_women(sw_women), .cancel(cancel),
      .state(state), .blink(blink), .en_child(en_child), .en_men(en_men),
      .en_women(en_women), .vend_child(vend_child), .vend_men(vend_men),
      .vend_women(vend_women), .change_out(change_out), .coin_reject(coin_reject),
      .credit(credit));

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_fail = 0;

   // Stimulus bits: {coin5, coin10, sw_child, sw_men, sw_women, cancel, rst}
   typedef struct packed {
      logic [6:0] stim;
      logic [1:0] st;
      logic [5:0] cr;
      logic [2:0] en;
      logic [2:0] vd;
      logic       chg;
      logic       rej;
   } vec_t;

   vec_t tbl [21];

   // Behavioural model: machine mode, credit in units, chosen item, dispense time left.
   int m_state = 0, m_credit = 0, m_item = 0, m_left = 0, m_cycles = 0;
   bit m_chg = 0, m_rej = 0;

   function automatic void model_step(input logic [6:0] in);
      bit c5, c10, sc, sm, sw, cn, rs, acc;
      int v, old, price;
      {c5, c10, sc, sm, sw, cn, rs} = in;
      if (rs) begin
         m_state = 0; m_credit = 0; m_item = 0; m_left = 0; m_cycles = 0;
         m_chg = 0; m_rej = 0;
         return;
      end
      m_cycles++;
      m_chg = 0;
      v = c10 ? 10 : 5;
      acc = (c5 ^ c10) && (m_state == 0 || (m_state == 1 && !cn)) && (m_credit + v <= CMAX);
      m_rej = (c5 | c10) && !acc;
      case (m_state)
         0: if (acc) begin m_credit += v; m_state = 1; end
         1: begin
            if (cn) m_state = 3;
            else begin
               old = m_credit;
               if (acc) m_credit += v;
               price = 0;
               if (sc && old >= PC) begin m_item = 0; price = PC; end
               else if (sm && old >= PM) begin m_item = 1; price = PM; end
               else if (sw && old >= PW) begin m_item = 2; price = PW; end
               if (price > 0) begin m_credit -= price; m_state = 2; m_left = DISP; end
            end
         end
         2: begin
            m_left--;
            if (m_left == 0) m_state = (m_credit > 0) ? 3 : 0;
         end
         default: begin
            if (m_credit > 0) begin m_credit -= 5; m_chg = 1; end
            else m_state = 0;
         end
      endcase
   endfunction

   function automatic logic [16:0] model_vec();
      logic [2:0] en, vd;
      en = (m_state == 1) ? {m_credit >= PC, m_credit >= PM, m_credit >= PW} : 3'b000;
      vd = (m_state == 2) ? (3'b100 >> m_item) : 3'b000;
      return {2'(m_state), 1'((m_cycles / BDIV) % 2), en, vd, m_chg, m_rej, 6'(m_credit)};
   endfunction

   function automatic logic [16:0] dut_vec();
      return {state, blink, en_child, en_men, en_women, vend_child, vend_men, vend_women,
              change_out, coin_reject, credit};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock: drive inputs, advance model on the edge, compare at the falling edge.
   task automatic tick(input logic [6:0] in);
      {coin5, coin10, sw_child, sw_men, sw_women, cancel, rst} = in;
      @(posedge clk);
      model_step(in);
      @(negedge clk);
      check("model", 32'(dut_vec()), 32'(model_vec()));
   endtask

   // Idle while the DUT stays in st, counting vend and change pulses seen.
   task automatic phase(input logic [1:0] st, output int vc, output int vm,
                        output int vw, output int ch);
      vc = 0; vm = 0; vw = 0; ch = 0;
      for (int k = 0; k < 64 && state == st; k++) begin
         vc += int'(vend_child); vm += int'(vend_men); vw += int'(vend_women);
         ch += int'(change_out);
         tick(7'b0);
      end
      check("phase_exit", 32'(state != st), 32'd1);
   endtask

   initial begin
      int vc, vm, vw, ch;
      {coin5, coin10, sw_child, sw_men, sw_women, cancel} = 6'b0;
      rst = 1'b1;

      tbl[0]  = {7'b0000001, 2'd0, 6'd0,  3'b000, 3'b000, 1'b0, 1'b0};
      tbl[1]  = {7'b0100000, 2'd1, 6'd10, 3'b100, 3'b000, 1'b0, 1'b0};
      tbl[2]  = {7'b1000000, 2'd1, 6'd15, 3'b110, 3'b000, 1'b0, 1'b0};
      tbl[3]  = {7'b0100000, 2'd1, 6'd25, 3'b111, 3'b000, 1'b0, 1'b0};
      tbl[4]  = {7'b0100000, 2'd1, 6'd35, 3'b111, 3'b000, 1'b0, 1'b0};
      tbl[5]  = {7'b0100000, 2'd1, 6'd45, 3'b111, 3'b000, 1'b0, 1'b0};
      tbl[6]  = {7'b0100000, 2'd1, 6'd55, 3'b111, 3'b000, 1'b0, 1'b0};
      tbl[7]  = {7'b0100000, 2'd1, 6'd55, 3'b111, 3'b000, 1'b0, 1'b1};
      tbl[8]  = {7'b1000000, 2'd1, 6'd60, 3'b111, 3'b000, 1'b0, 1'b0};
      tbl[9]  = {7'b1000000, 2'd1, 6'd60, 3'b111, 3'b000, 1'b0, 1'b1};
      tbl[10] = {7'b1100000, 2'd1, 6'd60, 3'b111, 3'b000, 1'b0, 1'b1};
      tbl[11] = {7'b0000100, 2'd2, 6'd40, 3'b000, 3'b001, 1'b0, 1'b0};
      tbl[12] = {7'b0000001, 2'd0, 6'd0,  3'b000, 3'b000, 1'b0, 1'b0};
      tbl[13] = {7'b1100000, 2'd0, 6'd0,  3'b000, 3'b000, 1'b0, 1'b1};
      tbl[14] = {7'b0010000, 2'd0, 6'd0,  3'b000, 3'b000, 1'b0, 1'b0};
      tbl[15] = {7'b0000010, 2'd0, 6'd0,  3'b000, 3'b000, 1'b0, 1'b0};
      tbl[16] = {7'b1000000, 2'd1, 6'd5,  3'b000, 3'b000, 1'b0, 1'b0};
      tbl[17] = {7'b0010000, 2'd1, 6'd5,  3'b000, 3'b000, 1'b0, 1'b0};
      tbl[18] = {7'b1000000, 2'd1, 6'd10, 3'b100, 3'b000, 1'b0, 1'b0};
      tbl[19] = {7'b0001000, 2'd1, 6'd10, 3'b100, 3'b000, 1'b0, 1'b0};
      tbl[20] = {7'b0000001, 2'd0, 6'd0,  3'b000, 3'b000, 1'b0, 1'b0};

      @(negedge clk);
      for (int i = 0; i < 21; i++) begin
         tick(tbl[i].stim);
         check($sformatf("vec%0d", i),
               32'({state, credit, en_child, en_men, en_women,
                    vend_child, vend_men, vend_women, change_out, coin_reject}),
               32'({tbl[i].st, tbl[i].cr, tbl[i].en, tbl[i].vd, tbl[i].chg, tbl[i].rej}));
         $display("vec %0d in=%b state=%0d credit=%0d", i, tbl[i].stim, state, credit);
      end

      // Buy men's item from 20: 8-cycle strobe, one 5-unit coin back.
      tick(7'b0000001); tick(7'b0100000); tick(7'b0100000);
      check("A_credit20", 32'(credit), 32'd20);
      tick(7'b0001000);
      check("A_disp", 32'({state, credit, vend_child, vend_men, vend_women}),
            32'({2'd2, 6'd5, 3'b010}));
      phase(2'd2, vc, vm, vw, ch);
      check("A_vend_men_len", 32'(vm), 32'(DISP));
      check("A_other_vend", 32'(vc + vw), 32'd0);
      check("A_to_change", 32'(state), 32'd3);
      phase(2'd3, vc, vm, vw, ch);
      check("A_change_cnt", 32'(ch), 32'd1);
      check("A_end", 32'({state, credit}), 32'd0);
      $display("seq A men from 20: vend=%0d change=%0d", vm, ch);

      // Child and women together from 20: child wins, 10 refunded.
      tick(7'b0000001); tick(7'b0100000); tick(7'b0100000);
      tick(7'b0010100);
      check("B_disp", 32'({state, credit, vend_child, vend_men, vend_women}),
            32'({2'd2, 6'd10, 3'b100}));
      phase(2'd2, vc, vm, vw, ch);
      check("B_vend_child_len", 32'(vc), 32'(DISP));
      check("B_other_vend", 32'(vm + vw), 32'd0);
      phase(2'd3, vc, vm, vw, ch);
      check("B_change_cnt", 32'(ch), 32'd2);
      check("B_end", 32'({state, credit}), 32'd0);
      $display("seq B child+women from 20: vend_child=%0d change=%0d", vc, ch);

      // Cancel with coin at 15: coin refused, three coins back.
      tick(7'b0000001); tick(7'b0100000); tick(7'b1000000);
      tick(7'b1000010);
      check("C_cancel", 32'({state, credit, coin_reject}), 32'({2'd3, 6'd15, 1'b1}));
      phase(2'd3, vc, vm, vw, ch);
      check("C_change_cnt", 32'(ch), 32'd3);
      check("C_end", 32'({state, credit}), 32'd0);
      $display("seq C cancel at 15: change=%0d", ch);

      // Exact-price purchase returns straight to IDLE.
      tick(7'b0000001); tick(7'b0100000); tick(7'b0010000);
      check("D_disp", 32'({state, credit}), 32'({2'd2, 6'd0}));
      phase(2'd2, vc, vm, vw, ch);
      check("D_idle", 32'(state), 32'd0);
      $display("seq D exact price: vend_child=%0d", vc);

      // Reset in the middle of dispensing clears every output and does not resume.
      tick(7'b0000001); tick(7'b0100000); tick(7'b0100000); tick(7'b0001000);
      tick(7'b0); tick(7'b0);
      tick(7'b0000001);
      check("E_rst_clear", 32'(dut_vec()), 32'd0);
      tick(7'b0); tick(7'b0);
      check("E_no_resume", 32'({state, vend_child, vend_men, vend_women, change_out}), 32'd0);
      $display("seq E reset mid-dispense: state=%0d credit=%0d", state, credit);

      // Random traffic against the model.
      for (int i = 0; i < 1500; i++) begin
         logic [6:0] in;
         in[6] = ($urandom_range(0, 9) < 2);
         in[5] = ($urandom_range(0, 9) < 2);
         in[4] = ($urandom_range(0, 5) == 0);
         in[3] = ($urandom_range(0, 5) == 0);
         in[2] = ($urandom_range(0, 5) == 0);
         in[1] = ($urandom_range(0, 19) == 0);
         in[0] = ($urandom_range(0, 199) == 0);
         tick(in);
      end
      $display("random phase done: %0d cycles", 1500);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/vend_fsm.md
VEND_FSM -- requirements
Module: vend_fsm

Interface
REQ-001 SHALL have parameter PRICE_CHILD, default 10, child item price in credit units.
REQ-002 SHALL have parameter PRICE_MEN, default 15, men item price.
REQ-003 SHALL have parameter PRICE_WOMEN, default 20, women item price.
REQ-004 SHALL have parameter CREDIT_MAX, default 60, maximum credit, at most 63.
REQ-005 SHALL have parameter BLINK_DIV, default 4, cycles per blink half-period, at least 1.
REQ-006 SHALL have parameter DISP_CYCLES, default 8, vend pulse length in cycles, at least 1.
REQ-007 SHALL have ports: clk  in  1  single clock, all logic on posedge.
REQ-008 SHALL have ports: rst  in  1  synchronous, active-high reset.
REQ-009 SHALL have ports: coin5, coin10  in  1 each  single-cycle coin pulses worth 5 and 10 units.
REQ-010 SHALL have ports: sw_child, sw_men, sw_women  in  1 each  selection pulses.
REQ-011 SHALL have ports: cancel  in  1  refund request.
REQ-012 SHALL have ports: state  out  2  00 IDLE, 01 SELECT, 10 DISPENSE, 11 CHANGE.
REQ-013 SHALL have ports: blink  out  1  free-running square wave.
REQ-014 SHALL have ports: en_child, en_men, en_women  out  1 each  item affordable.
REQ-015 SHALL have ports: vend_child, vend_men, vend_women  out  1 each  dispense strobes.
REQ-016 SHALL have ports: change_out  out  1  one 5-unit coin returned per high cycle.
REQ-017 SHALL have ports: coin_reject  out  1  coin returned unaccepted.
REQ-018 SHALL have ports: credit  out  6  current credit.

Function
REQ-019 All outputs SHALL be registered.
REQ-020 blink SHALL toggle every BLINK_DIV cycles, in all states.
REQ-021 A coin SHALL be accepted only in IDLE or SELECT, and only if credit + value <= CREDIT_MAX.
REQ-022 An accepted coin SHALL update credit on the next cycle.
REQ-023 Any unaccepted coin SHALL pulse coin_reject high for one cycle, with credit unchanged.
REQ-024 coin5 and coin10 asserted in the same cycle SHALL both be rejected.
REQ-025 IDLE SHALL go to SELECT on the cycle after the first accepted coin.
REQ-026 en_x SHALL be 1 only in SELECT, and only when credit >= PRICE_x; otherwise en_x SHALL be 0.
REQ-027 en_x SHALL reflect credit including any coin accepted in the previous cycle.
REQ-028 In SELECT, sw_x with en_x = 1 SHALL subtract PRICE_x from credit, latch item x and enter DISPENSE next cycle.
REQ-029 sw_x with en_x = 0 SHALL be ignored.
REQ-030 Simultaneous valid selections SHALL resolve with priority child > men > women.
REQ-031 cancel in SELECT SHALL enter CHANGE.
REQ-032 cancel SHALL win over a coin or selection in the same cycle; that coin SHALL be rejected.
REQ-033 cancel in any other state SHALL be ignored.
REQ-034 DISPENSE SHALL hold the latched vend_x high for exactly DISP_CYCLES cycles; the other vend outputs SHALL remain 0.
REQ-035 After DISPENSE, the FSM SHALL enter CHANGE if credit > 0, else IDLE.
REQ-036 CHANGE SHALL assert change_out for one cycle per 5 units, decrementing credit by 5 each cycle.
REQ-037 CHANGE SHALL enter IDLE on the cycle after credit reaches 0.
REQ-038 Credit SHALL always be a multiple of 5 and SHALL never underflow or exceed CREDIT_MAX.

Reset
REQ-039 rst sampled high SHALL, on that edge, set state=00 and blink=0, clear credit, en_*, vend_*, change_out, coin_reject and the blink/dispense counters.
REQ-040 rst SHALL override all inputs, including mid-DISPENSE or mid-CHANGE; a truncated vend or refund SHALL not resume.

Verification
REQ-041 Bench SHALL cover: reset, then coin10, coin5 -> state 01, credit 15, en_child=1, en_men=1, en_women=0.
REQ-042 Bench SHALL cover: credit 20, sw_men -> state 10, credit 5, vend_men high 8 cycles; then state 11, one change_out pulse; then state 00, credit 0.
REQ-043 Bench SHALL cover: credit 55, coin10 -> coin_reject 1 cycle, credit 55; coin5 -> credit 60.
REQ-044 Bench SHALL cover: credit 20, sw_child+sw_women together -> vend_child only, credit 10 refunded as 2 change_out cycles.
REQ-045 Bench SHALL cover: credit 15, cancel+coin5 same cycle -> coin_reject, 3 change_out cycles, state 00; and rst asserted during DISPENSE -> all outputs cleared next cycle.
